// File: rtl/uart_pkg.sv
// Shared constants and state encodings for the 8N1 UART.
package uart_pkg;

  localparam int CLK_HZ_DEF     = 50_000_000;
  localparam int BAUD_DEF       = 115_200;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Counter width able to hold 0..v-1, never narrower than one bit.
  function automatic int cnt_width(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divider pair: TX bit-enable (restartable at frame start) and free-running RX oversample tick.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int TX_DIV = 434,
  parameter int RX_DIV = 27
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_tx_restart,
  output logic o_tx_bit_en,
  output logic o_rx_tick
);

  localparam int TXW = cnt_width(TX_DIV);
  localparam int RXW = cnt_width(RX_DIV);

  logic [TXW-1:0] r_tx_cnt;
  logic [RXW-1:0] r_rx_cnt;
  logic           w_tx_wrap;
  logic           w_rx_wrap;

  assign w_tx_wrap = (r_tx_cnt == TXW'(TX_DIV - 1));
  assign w_rx_wrap = (r_rx_cnt == RXW'(RX_DIV - 1));

  // Restarting on acceptance makes every TX bit exactly TX_DIV clocks long.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_tx_cnt <= '0;
    end else if (i_tx_restart || w_tx_wrap) begin
      r_tx_cnt <= '0;
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_rx_cnt <= '0;
    end else if (w_rx_wrap) begin
      r_rx_cnt <= '0;
    end else begin
      r_rx_cnt <= r_rx_cnt + 1'b1;
    end
  end

  assign o_tx_bit_en = w_tx_wrap;
  assign o_rx_tick   = w_rx_wrap;

endmodule

// File: rtl/uart_8n1.sv
// Full-duplex 8N1 UART: one-byte-per-strobe transmitter and oversampling receiver
// with a sticky ready flag on the received byte.
module uart_8n1
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int BAUD       = BAUD_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       tx,
  output logic       tx_busy,
  input  logic       rx,
  output logic       rdy,
  input  logic       rdy_clr,
  output logic [7:0] dout
);

  localparam int TX_DIV = CLK_HZ / BAUD;
  localparam int RX_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int SCW    = cnt_width(OVERSAMPLE);
  localparam logic [SCW-1:0] MID_TICK  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_TICK = SCW'(OVERSAMPLE - 1);

  logic w_tx_bit_en;
  logic w_rx_tick;
  logic w_tx_accept;

  tx_state_t  r_tx_state;
  logic [7:0] r_tx_shift;
  logic [2:0] r_tx_bit_idx;
  logic       r_tx;
  logic       r_tx_busy;

  logic       r_rx_meta;
  logic       r_rx_sync;
  rx_state_t  r_rx_state;
  logic [SCW-1:0] r_rx_tcnt;
  logic [2:0] r_rx_bit_idx;
  logic [7:0] r_rx_shift;
  logic       r_rdy;
  logic [7:0] r_dout;

  assign w_tx_accept = (r_tx_state == TX_IDLE) && wr_en;

  uart_baud_gen #(
    .TX_DIV(TX_DIV),
    .RX_DIV(RX_DIV)
  ) u_baud_gen (
    .i_clk        (clk_50m),
    .i_srst       (reset),
    .i_tx_restart (w_tx_accept),
    .o_tx_bit_en  (w_tx_bit_en),
    .o_rx_tick    (w_rx_tick)
  );

  // tx/tx_busy are registered from the state, so the line trails the state by one clock.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_tx_state   <= TX_IDLE;
      r_tx_shift   <= '0;
      r_tx_bit_idx <= '0;
      r_tx         <= 1'b1;
      r_tx_busy    <= 1'b0;
    end else begin
      r_tx_busy <= (r_tx_state != TX_IDLE);
      case (r_tx_state)
        TX_START: r_tx <= 1'b0;
        TX_DATA:  r_tx <= r_tx_shift[0];
        default:  r_tx <= 1'b1;
      endcase

      case (r_tx_state)
        TX_IDLE: begin
          if (wr_en) begin
            r_tx_shift   <= din;
            r_tx_bit_idx <= '0;
            r_tx_state   <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_en) r_tx_state <= TX_DATA;
        end
        TX_DATA: begin
          if (w_tx_bit_en) begin
            r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit_idx <= r_tx_bit_idx + 3'd1;
            if (r_tx_bit_idx == 3'd7) r_tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (w_tx_bit_en) r_tx_state <= TX_IDLE;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // The completion set is written after the clear so a same-cycle byte keeps rdy high.
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      r_rx_state   <= RX_IDLE;
      r_rx_tcnt    <= '0;
      r_rx_bit_idx <= '0;
      r_rx_shift   <= '0;
      r_rdy        <= 1'b0;
      r_dout       <= '0;
    end else begin
      if (rdy_clr) r_rdy <= 1'b0;

      if (w_rx_tick) begin
        case (r_rx_state)
          RX_IDLE: begin
            if (!r_rx_sync) begin
              r_rx_tcnt  <= '0;
              r_rx_state <= RX_START;
            end
          end
          RX_START: begin
            if (r_rx_tcnt == MID_TICK) begin
              r_rx_tcnt    <= '0;
              r_rx_bit_idx <= '0;
              r_rx_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
          RX_DATA: begin
            if (r_rx_tcnt == FULL_TICK) begin
              r_rx_tcnt    <= '0;
              r_rx_shift   <= {r_rx_sync, r_rx_shift[7:1]};
              r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
              if (r_rx_bit_idx == 3'd7) r_rx_state <= RX_STOP;
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
          RX_STOP: begin
            if (r_rx_tcnt == FULL_TICK) begin
              r_rx_tcnt  <= '0;
              r_rx_state <= RX_IDLE;
              if (r_rx_sync) begin
                r_dout <= r_rx_shift;
                r_rdy  <= 1'b1;
              end
            end else begin
              r_rx_tcnt <= r_rx_tcnt + 1'b1;
            end
          end
          default: r_rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign tx      = r_tx;
  assign tx_busy = r_tx_busy;
  assign rdy     = r_rdy;
  assign dout    = r_dout;

endmodule

// File: tb/tb_uart_8n1.sv
// Randomised self-checking bench for uart_8n1 against a frame-level reference model.
module tb_uart_8n1;

  localparam int TX_DIV = 50_000_000 / 115_200;
  localparam int RX_DIV = 50_000_000 / (115_200 * 16);

  logic       clk_50m = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] din     = 8'h00;
  logic       wr_en   = 1'b0;
  logic       rdy_clr = 1'b0;
  logic       rx_drv  = 1'b1;
  logic       lb_en   = 1'b0;
  logic       rx_line;
  logic       tx;
  logic       tx_busy;
  logic       rdy;
  logic [7:0] dout;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  int          rdy_rises = 0;
  logic        rdy_q = 1'b0;

  // Reference model: last good byte delivered and sticky flag.
  logic [7:0] m_dout = 8'h00;
  logic       m_rdy  = 1'b0;

  assign rx_line = lb_en ? tx : rx_drv;

  uart_8n1 dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .din     (din),
    .wr_en   (wr_en),
    .tx      (tx),
    .tx_busy (tx_busy),
    .rx      (rx_line),
    .rdy     (rdy),
    .rdy_clr (rdy_clr),
    .dout    (dout)
  );

  always #10 clk_50m = ~clk_50m;

  always @(posedge clk_50m) cyc <= cyc + 1;

  always @(negedge clk_50m) begin
    if (rdy === 1'b1 && rdy_q !== 1'b1) begin
      rdy_rises = rdy_rises + 1;
      rise_cyc  = cyc;
    end
    rdy_q = rdy;
  end

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Line level of bit k of an 8N1 frame: start, 8 data bits LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int k, input logic stop);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return stop;
  endfunction

  task automatic tx_frame(input logic [7:0] b, input bit poke_mid);
    int hits;
    int busy_hits;
    din   = b;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    din   = 8'($urandom);
    chk("tx_busy_lat0", {31'd0, tx_busy}, 32'd0);
    step();
    busy_hits = 0;
    for (int k = 0; k < 10; k++) begin
      hits = 0;
      for (int c = 0; c < TX_DIV; c++) begin
        if (tx === frame_bit(b, k, 1'b1)) hits++;
        if (tx_busy === 1'b1) busy_hits++;
        if (poke_mid && k == 4 && c == 100) begin
          wr_en = 1'b1;
          din   = ~b;
        end else begin
          wr_en = 1'b0;
        end
        step();
      end
      chk($sformatf("tx_bit%0d_b%02h", k, b), hits, TX_DIV);
    end
    chk("tx_busy_len", busy_hits, 10 * TX_DIV);
    chk("tx_busy_end", {31'd0, tx_busy}, 32'd0);
    chk("tx_idle_end", {31'd0, tx}, 32'd1);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < TX_DIV; c++) begin
        rx_drv = frame_bit(b, k, stop);
        step();
      end
    end
    rx_drv = 1'b1;
    for (int c = 0; c < 50; c++) step();
  endtask

  task automatic pulse_clr();
    rdy_clr = 1'b1;
    step();
    rdy_clr = 1'b0;
    m_rdy   = 1'b0;
  endtask

  initial begin
    int          rises0;
    int unsigned s_cyc;
    int          lat;
    int          lat_lo;
    int          lat_hi;
    int          cnt;
    logic [7:0]  b;
    logic [7:0]  lb_bytes [3];

    lat_lo = (TX_DIV * 19) / 2 + 2 - 2 * RX_DIV;
    lat_hi = (TX_DIV * 19) / 2 + 2 + 3 * RX_DIV;
    lb_bytes[0] = 8'h00;
    lb_bytes[1] = 8'hFF;
    lb_bytes[2] = 8'h37;

    // Reset and idle
    for (int i = 0; i < 5; i++) step();
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) step();
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("rst_dout", {24'd0, dout}, {24'd0, m_dout});

    // Transmit 0x55 with an ignored mid-frame request
    tx_frame(8'h55, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (tx_busy === 1'b1) cnt++;
      step();
    end
    chk("wr_ignored", cnt, 0);

    // Receive 0xA5, check latency, then clear
    rises0 = rdy_rises;
    s_cyc  = cyc;
    rx_frame(8'hA5, 1'b1);
    m_dout = 8'hA5;
    m_rdy  = 1'b1;
    chk("rx_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("rx_dout", {24'd0, dout}, {24'd0, m_dout});
    chk("rx_rises", rdy_rises - rises0, 1);
    lat = int'(rise_cyc - s_cyc);
    chk($sformatf("rx_lat_%0d", lat), {31'd0, (lat >= lat_lo && lat <= lat_hi)}, 32'd1);
    pulse_clr();
    chk("clr_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("clr_dout", {24'd0, dout}, {24'd0, m_dout});

    // Glitch and framing error: nothing delivered
    rises0 = rdy_rises;
    rx_drv = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rx_drv = 1'b1;
    for (int i = 0; i < 1000; i++) step();
    chk("glitch_rises", rdy_rises - rises0, 0);
    rx_frame(8'($urandom), 1'b0);
    for (int i = 0; i < 1000; i++) step();
    chk("ferr_rises", rdy_rises - rises0, 0);
    chk("ferr_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("ferr_dout", {24'd0, dout}, {24'd0, m_dout});

    // Random external frames with random clears
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      rx_frame(b, 1'b1);
      m_dout = b;
      m_rdy  = 1'b1;
      chk("rnd_dout", {24'd0, dout}, {24'd0, m_dout});
      if ($urandom_range(1) == 1) pulse_clr();
      chk("rnd_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    end

    // Loopback: directed overrun sequence then random bytes
    pulse_clr();
    lb_en  = 1'b1;
    rises0 = rdy_rises;
    for (int i = 0; i < 3; i++) begin
      tx_frame(lb_bytes[i], 1'b0);
      m_dout = lb_bytes[i];
      m_rdy  = 1'b1;
      chk("lb_dout", {24'd0, dout}, {24'd0, m_dout});
      chk("lb_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    end
    chk("ovr_rises", rdy_rises - rises0, 1);
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      tx_frame(b, 1'b0);
      m_dout = b;
      m_rdy  = 1'b1;
      chk("lb_rnd_dout", {24'd0, dout}, {24'd0, m_dout});
    end

    // Reset during bit 4 of both a TX and an RX frame
    lb_en = 1'b0;
    b     = 8'($urandom);
    din   = b;
    wr_en = 1'b1;
    for (int c = 0; c < 4 * TX_DIV + TX_DIV / 2; c++) begin
      rx_drv = frame_bit(b, c / TX_DIV, 1'b1);
      step();
      wr_en = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    step();
    m_dout = 8'h00;
    m_rdy  = 1'b0;
    chk("mid_rst_tx", {31'd0, tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy}, {31'd0, m_rdy});
    chk("mid_rst_dout", {24'd0, dout}, {24'd0, m_dout});
    reset  = 1'b0;
    rx_drv = 1'b1;
    rises0 = rdy_rises;
    for (int i = 0; i < 1000; i++) step();
    chk("post_rst_rises", rdy_rises - rises0, 0);
    lb_en = 1'b1;
    tx_frame(8'h80, 1'b0);
    m_dout = 8'h80;
    m_rdy  = 1'b1;
    chk("post_rst_dout", {24'd0, dout}, {24'd0, m_dout});
    chk("post_rst_rdy", {31'd0, rdy}, {31'd0, m_rdy});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_8n1.md
# uart_8n1

Full-duplex 8N1 UART for the 50 MHz fabric. It serialises one byte per write request onto `tx` and deserialises bytes from `rx` into a holding register with a sticky ready flag. It sits between the request/alarm state machine and the external microcontroller link. The state machine writes request codes through `din`/`wr_en` and reads replies through `dout`/`rdy`/`rdy_clr`.

## Interface
- `CLK_HZ`, 50_000_000, clock frequency in Hz.
- `BAUD`, 115200, line bit rate.
- `OVERSAMPLE`, 16, receive samples per bit.

Ports:
- `clk_50m`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `din`  in  8  byte to transmit; sampled only when `wr_en` is accepted.
- `wr_en`  in  1  transmit request, one-cycle strobe.
- `tx`  out  1  serial output; idles high.
- `tx_busy`  out  1  high while a frame is in progress.
- `rx`  in  1  asynchronous serial input.
- `rdy`  out  1  sticky received-byte-valid flag.
- `rdy_clr`  in  1  clears `rdy`.
- `dout`  out  8  last correctly framed received byte.

## Operation
Derived constants (integer division, truncated):
- TX_DIV = CLK_HZ/BAUD, which is 434 at the defaults.
- RX_DIV = CLK_HZ/(BAUD*OVERSAMPLE), which is 27 at the defaults.

Reset values:
- `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0.
- Both the transmitter and the receiver return to IDLE.
- All counters are cleared.

Transmitter, states IDLE → START → DATA → STOP → IDLE:
- In IDLE, `wr_en`=1 is accepted: `din` is latched, the bit counter is restarted and the state goes to START.
- `wr_en` is ignored while `tx_busy`=1. It is not queued.
- Frame: start bit 0, then `din[0]`…`din[7]` (LSB first), then stop bit 1.
- Each bit is held for exactly TX_DIV clocks.
- After the stop bit the state returns to IDLE with `tx`=1.

Receiver:
- `rx` passes through a 2-flop synchroniser before use.
- A free-running tick fires every RX_DIV clocks.
- IDLE: a synchronised low sampled on a tick enters START, and the tick count is cleared.
- START: the line is re-checked on the 8th tick (mid-bit).
  - If high, the event is a false start and the receiver returns to IDLE.
  - If low, the receiver enters DATA.
- DATA: eight bits are sampled LSB first, every 16 ticks, at mid-bit.
- STOP: the line is sampled at the middle of the stop bit.
  - If high, `dout` is loaded with the byte and `rdy` is set for the next cycle onward.
  - If low (framing error), the byte is discarded and `rdy`/`dout` are unchanged.
  - In both cases the receiver returns to IDLE.
- `rdy` stays high until `rdy_clr`=1 is sampled, then clears on the next edge.
- Overrun: a new good byte overwrites `dout` and `rdy` stays 1. No error flag exists.
- If `rdy_clr` and a new byte completion occur in the same cycle, set wins and `rdy`=1.
- Transmit and receive paths are fully independent; loopback of `tx` to `rx` is legal.

## Timing
Transmit:
- `wr_en` is accepted at edge N.
- `tx_busy`=1 and `tx`=0 from edge N+1.
- Data bit k starts at edge N+1+(k+1)·TX_DIV.
- The stop bit starts at N+1+9·TX_DIV.
- `tx_busy` falls at N+1+10·TX_DIV.
- A new `wr_en` is accepted in that same cycle, giving back-to-back frames.

Receive:
- Latency from the falling edge of the start bit to `rdy` is about 9.5 bit times + 2 synchroniser clocks + up to one RX tick of jitter.
- The bench allows ±2 ticks.

`reset` mid-frame:
- Forces `tx`=1, `tx_busy`=0 and `rdy`=0 on the next edge.
- The partial RX byte is dropped.

## Structure
- A shared package `uart_pkg` holds:
  - the default CLK_HZ/BAUD/OVERSAMPLE constants;
  - the TX and RX state enums.
- One sub-module, `uart_baud_gen`, is natural. It provides divider counters producing the TX bit-enable and the RX oversample tick. The TX divider restarts on `wr_en` acceptance.
- TX and RX FSMs live in the top level.
- Total size is roughly 150–250 lines.

## Test plan
- Reset, then idle for 1000 cycles → `tx`=1, `tx_busy`=0, `rdy`=0, `dout`=0x00.
- `wr_en` pulse with `din`=0x55 → `tx` = 0,1,0,1,0,1,0,1,0,1, each bit 434 cycles. `tx_busy` high for exactly 4340 cycles. A second `wr_en` pulse mid-frame is ignored.
- Drive an `rx` frame for 0xA5 at 434 cycles/bit → `rdy`=1, `dout`=0xA5. Pulse `rdy_clr` → `rdy`=0 next cycle. `dout` holds 0xA5.
- A 100-cycle low glitch on `rx` → no `rdy`. Then a frame with stop bit 0 → no `rdy`, `dout` unchanged.
- Loopback `tx`→`rx`, then send 0x00, 0xFF and 0x37 back-to-back without clearing → `rdy` stays 1 and `dout`=0x37 at the end. Overrun overwrites.
- Assert `reset` during bit 4 of both a TX and an RX frame → outputs return to their reset values. The next 0x80 frame is sent and received correctly.
